ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 103 ++++++++++
 rtl/ctrl_decode.sv | 110 +++++++++++
 rtl/ctrl_pipe.sv | 133 +++++++++++++
 tb/tb_ctrl_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the control pipeline: opcode map, ctrl bundle, FSM states.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package ctrl_pkg;

    // Number of meaningful bits in the ctrl bundle; wider ports are zero-padded at the MSB end.
    localparam int CTRL_BITS = 19;

    // WISC-SP13 opcode map (instruction bits [15:11])
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ARITH = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    // Destination register select: R-format rd, I-format-1 rd, rs field (LBI/SLBI/STU), R7 (link)
    typedef enum logic [1:0] {
        RD_RD = 2'd0,
        RD_I1 = 2'd1,
        RD_RS = 2'd2,
        RD_R7 = 2'd3
    } reg_dst_e;

    // Immediate select: field width and sign/zero extension
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM5_S   = 3'd1,
        IMM5_Z   = 3'd2,
        IMM8_S   = 3'd3,
        IMM8_Z   = 3'd4,
        IMM11_S  = 3'd5
    } imm_sel_e;

    // Field order is MSB first: vld is bit 18, illegal is bit 0.
    typedef struct packed {
        logic     vld;
        logic     halt;
        logic     jump;
        logic     jump_imm;
        logic     link;
        logic [2:0] branch;
        logic     mem_read;
        logic     mem_to_reg;
        logic     mem_write;
        logic     alu_src;
        logic     reg_write;
        reg_dst_e reg_dst;
        imm_sel_e imm_sel;
        logic     illegal;
    } ctrl_t;

    localparam int OFF_VLD        = 18;
    localparam int OFF_HALT       = 17;
    localparam int OFF_JUMP       = 16;
    localparam int OFF_JUMP_IMM   = 15;
    localparam int OFF_LINK       = 14;
    localparam int OFF_BRANCH     = 11;
    localparam int OFF_MEM_READ   = 10;
    localparam int OFF_MEM_TO_REG = 9;
    localparam int OFF_MEM_WRITE  = 8;
    localparam int OFF_ALU_SRC    = 7;
    localparam int OFF_REG_WRITE  = 6;
    localparam int OFF_REG_DST    = 4;
    localparam int OFF_IMM_SEL    = 1;
    localparam int OFF_ILLEGAL    = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // branch[2] flags a branch, branch[1:0] carries the condition (EQZ/NEZ/LTZ/GEZ)
    function automatic logic [2:0] branch_code(input logic [1:0] cond);
        return {1'b1, cond};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into the ctrl bundle; zero bundle when invalid or not running.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; callers gate acceptance. Macro CTRL_PIPE_EXC_EN sets the illegal bit on unassigned opcodes.
// Ports: opcode (instruction MSBs), instr_vld, run (FSM in RUN) -> ctrl (packed ctrl_t).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_vld,
    input  logic                run,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        if (instr_vld && run) begin
            ctrl.vld = 1'b1;
            case (opcode)
                OP_HALT: ctrl.halt = 1'b1;
                OP_NOP: ;
                OP_J: begin
                    ctrl.jump     = 1'b1;
                    ctrl.jump_imm = 1'b1;
                    ctrl.imm_sel  = IMM11_S;
                end
                OP_JR: begin
                    ctrl.jump    = 1'b1;
                    ctrl.imm_sel = IMM8_S;
                end
                OP_JAL: begin
                    ctrl.jump      = 1'b1;
                    ctrl.jump_imm  = 1'b1;
                    ctrl.link      = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_R7;
                    ctrl.imm_sel   = IMM11_S;
                end
                OP_JALR: begin
                    ctrl.jump      = 1'b1;
                    ctrl.link      = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_R7;
                    ctrl.imm_sel   = IMM8_S;
                end
                OP_ADDI, OP_SUBI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_I1;
                    ctrl.imm_sel   = IMM5_S;
                end
                OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_I1;
                    ctrl.imm_sel   = IMM5_Z;
                end
                OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                    ctrl.branch  = branch_code(opcode[1:0]);
                    ctrl.imm_sel = IMM8_S;
                end
                OP_ST: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.imm_sel   = IMM5_S;
                end
                OP_LD: begin
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_I1;
                    ctrl.imm_sel    = IMM5_S;
                end
                OP_SLBI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RS;
                    ctrl.imm_sel   = IMM8_Z;
                end
                OP_STU: begin
                    // store with base-register update
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RS;
                    ctrl.imm_sel   = IMM5_S;
                end
                OP_LBI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RS;
                    ctrl.imm_sel   = IMM8_S;
                end
                OP_BTR, OP_SHIFT, OP_ARITH, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RD;
                end
                default: begin
                    // Unassigned opcodes: flagged illegal, otherwise they behave as NOP.
`ifdef CTRL_PIPE_EXC_EN
                    ctrl.illegal = 1'b1;
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Decode + NUM_STAGES-deep control pipeline with halt drain FSM (RUN/DRAIN/HALTED).
// Latency: ex_ctrl 1 cycle after acceptance, wb_ctrl NUM_STAGES cycles after acceptance.
// Backpressure: stall/flush insert a bubble into EX; mem_stall freezes all stages, FSM and counter.
// Ports: clk, rst (async active-high), instr_id/instr_vld/stall/flush/mem_stall in;
//        id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl, fetch_hold, halted, exc out.
// Option: CTRL_PIPE_EXC_EN enables the exc pulse and bubbling of unassigned opcodes.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int OPCODE_W   = 5,
    parameter int NUM_STAGES = 3,
    parameter int CTRL_W     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_id,
    input  logic               instr_vld,
    input  logic               stall,
    input  logic               flush,
    input  logic               mem_stall,
    output logic [CTRL_W-1:0]  id_ctrl,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [CTRL_W-1:0]  mem_ctrl,
    output logic [CTRL_W-1:0]  wb_ctrl,
    output logic               fetch_hold,
    output logic               halted,
    output logic               exc
);

    state_e              state;
    state_e              state_nxt;
    logic [2:0]          cnt;
    logic [2:0]          cnt_nxt;
    ctrl_t               dec;
    logic                run;
    logic                bubble;
    logic                halt_enter;
    logic [CTRL_W-1:0]   ex_in;
    logic [CTRL_W-1:0]   stg [NUM_STAGES];
    logic                unused_lo;

    // Only the opcode field matters for control decode.
    assign unused_lo = ^instr_id[INSTR_W-OPCODE_W-1:0];

    assign run = (state == ST_RUN);

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode    (instr_id[INSTR_W-1 -: OPCODE_W]),
        .instr_vld (instr_vld),
        .run       (run),
        .ctrl      (dec)
    );

    assign id_ctrl = CTRL_W'(dec);

    // An illegal instruction never reaches EX; its only trace is the exc pulse.
    assign bubble     = stall | flush | dec.illegal;
    assign ex_in      = bubble ? '0 : id_ctrl;
    assign halt_enter = dec.halt & ~stall & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stg[i] <= '0;
            end
        end else if (!mem_stall) begin
            stg[0] <= ex_in;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign ex_ctrl  = stg[0];
    assign mem_ctrl = stg[1];
    assign wb_ctrl  = stg[NUM_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter tracks how many more unfrozen edges the halt needs to reach WB.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        halted     = 1'b0;
        fetch_hold = 1'b0;
        if (!mem_stall) begin
            case (state)
                ST_RUN: begin
                    if (halt_enter) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = 3'(NUM_STAGES - 1);
                    end
                end
                ST_DRAIN: begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = ST_HALTED;
                    end
                end
                ST_HALTED: ;
                default: state_nxt = ST_RUN;
            endcase
        end
        halted     = (state == ST_HALTED);
        // dec.halt already implies RUN and instr_vld
        fetch_hold = ~rst & (~run | dec.halt);
    end

`ifdef CTRL_PIPE_EXC_EN
    // Cleared on frozen edges so the pulse lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc <= 1'b0;
        end else begin
            exc <= ~mem_stall & dec.illegal & ~stall & ~flush;
        end
    end
`else
    assign exc = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed table followed by randomized episodes,
// expected values from a queue-based reference model, compared by a separate monitor.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int INSTR_W = 16;
    localparam int NS      = 3;
    localparam int CW      = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [INSTR_W-1:0] instr_id = '0;
    logic              instr_vld = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              mem_stall = 1'b0;
    logic [CW-1:0]     id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
    logic              fetch_hold, halted, exc;

    ctrl_pipe #(
        .INSTR_W    (INSTR_W),
        .OPCODE_W   (5),
        .NUM_STAGES (NS),
        .CTRL_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_id   (instr_id),
        .instr_vld  (instr_vld),
        .stall      (stall),
        .flush      (flush),
        .mem_stall  (mem_stall),
        .id_ctrl    (id_ctrl),
        .ex_ctrl    (ex_ctrl),
        .mem_ctrl   (mem_ctrl),
        .wb_ctrl    (wb_ctrl),
        .fetch_hold (fetch_hold),
        .halted     (halted),
        .exc        (exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] id, ex, mem, wb;
        logic          fh, hd, xc;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        bit          v, s, f, ms, r;
        int          rep;
    } vec_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_err = 0;

    // Reference model state: queue of stage contents (front = EX) and halt progress.
    logic [CW-1:0] mq[$];
    bit            m_seen;
    int            m_age;
    bit            m_exc;
    int            cyc = 0;

    // Expected bundle per opcode, written by instruction class.
    function automatic ctrl_t ref_decode(input logic [4:0] op);
        ctrl_t c;
        c = '0;
        c.vld = 1'b1;
        if (op == 5'b00000) begin
            c.halt = 1'b1;
        end else if (op[4:2] == 3'b001) begin
            c.jump      = 1'b1;
            c.jump_imm  = ~op[0];
            c.link      = op[1];
            c.reg_write = op[1];
            if (op[1]) c.reg_dst = RD_R7;
            c.imm_sel = op[0] ? IMM8_S : IMM11_S;
        end else if (op[4:2] == 3'b010) begin
            c.alu_src = 1'b1; c.reg_write = 1'b1; c.reg_dst = RD_I1;
            c.imm_sel = op[1] ? IMM5_Z : IMM5_S;
        end else if (op[4:2] == 3'b011) begin
            c.branch = {1'b1, op[1:0]}; c.imm_sel = IMM8_S;
        end else if (op[4:2] == 3'b101) begin
            c.alu_src = 1'b1; c.reg_write = 1'b1; c.reg_dst = RD_I1; c.imm_sel = IMM5_Z;
        end else if (op == 5'b10000) begin
            c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM5_S;
        end else if (op == 5'b10001) begin
            c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1;
            c.reg_write = 1'b1; c.reg_dst = RD_I1; c.imm_sel = IMM5_S;
        end else if (op == 5'b10010) begin
            c.alu_src = 1'b1; c.reg_write = 1'b1; c.reg_dst = RD_RS; c.imm_sel = IMM8_Z;
        end else if (op == 5'b10011) begin
            c.mem_write = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
            c.reg_dst = RD_RS; c.imm_sel = IMM5_S;
        end else if (op == 5'b11000) begin
            c.alu_src = 1'b1; c.reg_write = 1'b1; c.reg_dst = RD_RS; c.imm_sel = IMM8_S;
        end else if (op[4:3] == 2'b11) begin
            c.reg_write = 1'b1; c.reg_dst = RD_RD;
        end else if (op[4:1] == 4'b0001) begin
`ifdef CTRL_PIPE_EXC_EN
            c.illegal = 1'b1;
`endif
        end
        return c;
    endfunction

    task automatic model_clear();
        mq = {};
        for (int i = 0; i < NS; i++) mq.push_back('0);
        m_seen = 1'b0;
        m_age  = 0;
        m_exc  = 1'b0;
    endtask

    task automatic step(input logic [15:0] ins, input bit v, input bit s, input bit f,
                        input bit ms, input bit r);
        exp_t          e;
        ctrl_t         d;
        logic [CW-1:0] idv, exin;
        bit            acc_halt, ill;
        @(posedge clk);
        #1;
        instr_id = ins; instr_vld = v; stall = s; flush = f; mem_stall = ms; rst = r;
        if (r) model_clear();
        d = '0;
        if (v && !m_seen) d = ref_decode(ins[15:11]);
        idv      = CW'(d);
        ill      = d.illegal;
        exin     = (s || f || ill) ? '0 : idv;
        acc_halt = d.halt && !s && !f;
        e.id  = idv;
        e.ex  = mq[0];
        e.mem = mq[1];
        e.wb  = mq[NS-1];
        e.fh  = !r && (m_seen || d.halt);
        e.hd  = m_seen && (m_age >= NS);
        e.xc  = m_exc;
        e.cyc = cyc;
        sb.push_back(e);
        cyc++;
        if (!r) begin
            if (ms) begin
                m_exc = 1'b0;
            end else begin
                mq.push_front(exin);
                void'(mq.pop_back());
                if (m_seen) m_age++;
                if (acc_halt) begin
                    m_seen = 1'b1;
                    m_age  = 1;
                end
                m_exc = ill && !s && !f;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] expv,
                       input int c);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, act, expv);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("id_ctrl",    id_ctrl,       e.id,       e.cyc);
                chk("ex_ctrl",    ex_ctrl,       e.ex,       e.cyc);
                chk("mem_ctrl",   mem_ctrl,      e.mem,      e.cyc);
                chk("wb_ctrl",    wb_ctrl,       e.wb,       e.cyc);
                chk("fetch_hold", CW'(fetch_hold), CW'(e.fh), e.cyc);
                chk("halted",     CW'(halted),   CW'(e.hd),  e.cyc);
                chk("exc",        CW'(exc),      CW'(e.xc),  e.cyc);
            end
        end
    end

    // ins, vld, stall, flush, mem_stall, rst, repeat
    vec_t dir[] = '{
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2},   // reset state
        '{16'hD9A4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},   // ADD through the pipe
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4},
        '{16'h8C41, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2},   // LD held by stall
        '{16'h8C41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4},
        '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2},   // halt stalled: no state change
        '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},   // halt accepted
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14},  // drain then sticky halted
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1},
        '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1},   // halt flushed
        '{16'h0800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3},
        '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1},   // stall+flush on halt
        '{16'h4123, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1},
        '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},   // halt, then freeze during drain
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1},
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4},
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6},
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1},
        '{16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},   // unassigned opcode 00010
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4},
        '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},   // reset mid-drain
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1},
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1},
        '{16'hD9A4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1},
        '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4}
    };

    initial begin
        logic [15:0] ins;
        logic [4:0]  op;
        model_clear();
        foreach (dir[k]) begin
            for (int j = 0; j < dir[k].rep; j++) begin
                step(dir[k].ins, dir[k].v, dir[k].s, dir[k].f, dir[k].ms, dir[k].r);
            end
        end
        for (int ep = 0; ep < 30; ep++) begin
            step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            for (int c = 0; c < 40; c++) begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'b00000 && ($urandom % 4) != 0) op = 5'b00001;
                ins = {op, 11'($urandom)};
                step(ins, ($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
                     ($urandom % 6) == 0, ($urandom % 60) == 0);
            end
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
